// File: rtl/syn_vcortex_sram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : syn_vcortex_pkg                                                 |
// | Purpose  : Shared types and constants for the vcortex pixel-SRAM arbiter:  |
// |            requester indices, sequencer state encoding, SRAM widths.       |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package syn_vcortex_pkg;

   localparam int unsigned c_SRAM_ADDR_W = 18;
   localparam int unsigned c_SRAM_DATA_W = 16;

   // Requester slot numbering on the req/ack vectors.
   typedef enum logic [1:0] {
      REQ_VGA = 2'd0,
      REQ_GPU = 2'd1,
      REQ_LB  = 2'd2
   } req_id_e;

   // SRAM cycle sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR1  = 2'd2,
      ST_WR2  = 2'd3
   } state_e;

endpackage : syn_vcortex_pkg
`default_nettype wire

// File: rtl/syn_vcortex_sram_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : syn_rr_arb2                                                     |
// | Purpose  : Two-way round-robin picker with a registered 1-bit pointer.     |
// |            Bit 0 is preferred out of reset; after a grant the pointer      |
// |            moves to favour the other requester.                            |
// | Ports    : clk, rst (async, active-high)                                   |
// |            req_i[1:0] requests, en_i slot open, gnt_o[1:0] one-hot grant   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module syn_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   // ptr_q = 0 favours req_i[0], ptr_q = 1 favours req_i[1].
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (!ptr_q) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
         end else begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
         end
      end
      ptr_d = ptr_q;
      if (gnt_o[0])      ptr_d = 1'b1;
      else if (gnt_o[1]) ptr_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

endmodule : syn_rr_arb2
`default_nettype wire

// File: rtl/syn_vcortex_sram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : syn_vcortex_sram_arb                                            |
// | Purpose  : Shares the external pixel SRAM between VGA fetch (0), GPU (1)   |
// |            and local-bus host (2). Converts req/ack transactions into      |
// |            timed SRAM read (1 cycle) and write (2 cycle) sequences and     |
// |            returns read data tagged with a one-hot requester strobe.       |
// | Ports    : sys_clk_50, sys_rst (async, active-high)                        |
// |            req_i/wr_i/addr_i/wdata_i/be_i  requester side, index = id      |
// |            ack_o one-hot grant, rd_valid_o/rdata_o read return             |
// |            sram_* pins: address, write data, drive enable, read data,      |
// |            active-low ce/oe/we/lb/ub strobes                               |
// | Options  : SYN_VCORTEX_SRAM_ARB_STARVE_CNT_EN - after STARVE_LIMIT         |
// |            consecutive VGA grants with GPU/LB waiting, one slot is handed  |
// |            to the round-robin winner. Undefined: strict VGA priority.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module syn_vcortex_sram_arb
   import syn_vcortex_pkg::*;
#(
   parameter int unsigned SRAM_ADDR_W  = c_SRAM_ADDR_W,
   parameter int unsigned SRAM_DATA_W  = c_SRAM_DATA_W,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                        sys_clk_50,
   input  logic                        sys_rst,
   input  logic [2:0]                  req_i,
   input  logic [2:0]                  wr_i,
   input  logic [2:0][SRAM_ADDR_W-1:0] addr_i,
   input  logic [2:0][SRAM_DATA_W-1:0] wdata_i,
   input  logic [2:0][1:0]             be_i,
   output logic [2:0]                  ack_o,
   output logic [2:0]                  rd_valid_o,
   output logic [SRAM_DATA_W-1:0]      rdata_o,
   output logic [SRAM_ADDR_W-1:0]      sram_addr_o,
   output logic [SRAM_DATA_W-1:0]      sram_wdata_o,
   output logic                        sram_dq_oe_o,
   input  logic [SRAM_DATA_W-1:0]      sram_rdata_i,
   output logic                        sram_ce_n_o,
   output logic                        sram_oe_n_o,
   output logic                        sram_we_n_o,
   output logic                        sram_lb_n_o,
   output logic                        sram_ub_n_o
);

   state_e                 state_q, state_d;
   logic                   ready_q;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic                   dq_oe_q, dq_oe_d;
   logic                   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;
   logic                   lb_n_q, lb_n_d;
   logic                   ub_n_q, ub_n_d;
   logic [2:0]             rd_id_q, rd_id_d;
   logic [2:0]             rd_valid_q, rd_valid_d;
   logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;

   logic                   w_slot;
   logic                   w_oth_req;
   logic                   w_force;
   logic                   w_vga_win;
   logic [1:0]             w_rr_gnt;
   logic [SRAM_ADDR_W-1:0] w_sel_addr;
   logic [SRAM_DATA_W-1:0] w_sel_wdata;
   logic [1:0]             w_sel_be;
   logic                   w_sel_wr;
   logic                   w_unused;

   // WR1 is the only state that cannot accept a new cycle; ready_q keeps
   // acks off for the first cycle after reset release.
   assign w_slot    = ready_q && (state_q != ST_WR1);
   assign w_oth_req = req_i[REQ_GPU] | req_i[REQ_LB];

`ifdef SYN_VCORTEX_SRAM_ARB_STARVE_CNT_EN
   localparam int unsigned c_CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [c_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign w_force = (starve_cnt_q >= c_CNT_W'(STARVE_LIMIT)) && w_oth_req;

   // Counts VGA grants that happened while someone else was waiting.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!w_oth_req) begin
         starve_cnt_d = '0;
      end else if (ack_o[REQ_VGA]) begin
         if (starve_cnt_q < c_CNT_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
      end else if (ack_o[REQ_GPU] || ack_o[REQ_LB]) begin
         starve_cnt_d = '0;
      end
   end

   always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
      if (sys_rst) starve_cnt_q <= '0;
      else         starve_cnt_q <= starve_cnt_d;
   end
`else
   assign w_force = 1'b0;
`endif

   assign w_vga_win = w_slot && req_i[REQ_VGA] && !w_force;

   syn_rr_arb2 u_rr (
      .clk   (sys_clk_50),
      .rst   (sys_rst),
      .req_i ({req_i[REQ_LB], req_i[REQ_GPU]}),
      .en_i  (w_slot && !w_vga_win),
      .gnt_o (w_rr_gnt)
   );

   assign ack_o = {w_rr_gnt, w_vga_win};

   // VGA's write bit is ignored: it only ever reads.
   assign w_unused = wr_i[REQ_VGA] ^ (STARVE_LIMIT == 0);

   // One-hot mux of the granted requester's transaction.
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_be    = '0;
      w_sel_wr    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (ack_o[i]) begin
            w_sel_addr  = addr_i[i];
            w_sel_wdata = wdata_i[i];
            w_sel_be    = be_i[i];
            w_sel_wr    = (i != 0) && wr_i[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      dq_oe_d    = dq_oe_q;
      ce_n_d     = ce_n_q;
      oe_n_d     = oe_n_q;
      we_n_d     = we_n_q;
      lb_n_d     = lb_n_q;
      ub_n_d     = ub_n_q;
      rd_id_d    = '0;
      rd_valid_d = '0;
      rdata_d    = rdata_q;

      // Read data is captured at the end of the RD cycle and tagged with the
      // requester id recorded at grant time.
      if (state_q == ST_RD) begin
         rd_valid_d = rd_id_q;
         rdata_d    = sram_rdata_i;
      end

      if (state_q == ST_WR1) begin
         // Release we_n while keeping address/data/drive for hold time.
         state_d = ST_WR2;
         we_n_d  = 1'b1;
      end else if (|ack_o) begin
         addr_d = w_sel_addr;
         lb_n_d = ~w_sel_be[0];
         ub_n_d = ~w_sel_be[1];
         ce_n_d = 1'b0;
         if (w_sel_wr) begin
            state_d = ST_WR1;
            wdata_d = w_sel_wdata;
            we_n_d  = 1'b0;
            oe_n_d  = 1'b1;
            dq_oe_d = 1'b1;
         end else begin
            // dq_oe drops on the same edge oe_n falls, so a read after a
            // write never sees both drivers enabled.
            state_d = ST_RD;
            oe_n_d  = 1'b0;
            we_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            rd_id_d = ack_o;
         end
      end else begin
         state_d = ST_IDLE;
         ce_n_d  = 1'b1;
         oe_n_d  = 1'b1;
         we_n_d  = 1'b1;
         lb_n_d  = 1'b1;
         ub_n_d  = 1'b1;
         dq_oe_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         dq_oe_q    <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         lb_n_q     <= 1'b1;
         ub_n_q     <= 1'b1;
         rd_id_q    <= '0;
         rd_valid_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= 1'b1;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         dq_oe_q    <= dq_oe_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         lb_n_q     <= lb_n_d;
         ub_n_q     <= ub_n_d;
         rd_id_q    <= rd_id_d;
         rd_valid_q <= rd_valid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rd_valid_o   = rd_valid_q;
   assign rdata_o      = rdata_q;
   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign sram_dq_oe_o = dq_oe_q;
   assign sram_ce_n_o  = ce_n_q;
   assign sram_oe_n_o  = oe_n_q;
   assign sram_we_n_o  = we_n_q;
   assign sram_lb_n_o  = lb_n_q;
   assign sram_ub_n_o  = ub_n_q;

endmodule : syn_vcortex_sram_arb
`default_nettype wire

// File: tb/tb_syn_vcortex_sram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_syn_vcortex_sram_arb                                         |
// | Purpose  : Self-checking bench for syn_vcortex_sram_arb: directed vector   |
// |            table, multi-cycle corner sequences and a random phase checked  |
// |            against a transaction-level arbitration/memory model.           |
// | Options  : honours SYN_VCORTEX_SRAM_ARB_STARVE_CNT_EN like the design.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_syn_vcortex_sram_arb;

   localparam int AW  = 18;
   localparam int DW  = 16;
   localparam int LIM = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [2:0]          req, wr;
   logic [2:0][AW-1:0]  addr;
   logic [2:0][DW-1:0]  wdata;
   logic [2:0][1:0]     be;
   logic [2:0]          ack, rd_valid;
   logic [DW-1:0]       rdata, s_wdata, s_rdata;
   logic [AW-1:0]       s_addr;
   logic                dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;
   logic [4:0]          pins;

   int n_chk  = 0;
   int n_fail = 0;

   always #10 clk = ~clk;

   syn_vcortex_sram_arb #(
      .SRAM_ADDR_W  (AW),
      .SRAM_DATA_W  (DW),
      .STARVE_LIMIT (LIM)
   ) dut (
      .sys_clk_50   (clk),
      .sys_rst      (rst),
      .req_i        (req),
      .wr_i         (wr),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .be_i         (be),
      .ack_o        (ack),
      .rd_valid_o   (rd_valid),
      .rdata_o      (rdata),
      .sram_addr_o  (s_addr),
      .sram_wdata_o (s_wdata),
      .sram_dq_oe_o (dq_oe),
      .sram_rdata_i (s_rdata),
      .sram_ce_n_o  (ce_n),
      .sram_oe_n_o  (oe_n),
      .sram_we_n_o  (we_n),
      .sram_lb_n_o  (lb_n),
      .sram_ub_n_o  (ub_n)
   );

   assign pins = {ce_n, oe_n, we_n, lb_n, ub_n};

   // Unwritten locations read back an address-derived pattern.
   function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 16'h5A5A;
   endfunction

   // ---------------- pin-level asynchronous SRAM model ----------------
   logic [DW-1:0] sram_mem [int];

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
      return init_pat(a);
   endfunction

   always @(negedge clk) begin
      logic [DW-1:0] w;
      if (!ce_n && !we_n) begin
         w = mem_rd(s_addr);
         if (!lb_n) w[7:0]  = s_wdata[7:0];
         if (!ub_n) w[15:8] = s_wdata[15:8];
         sram_mem[int'(s_addr)] = w;
      end
      s_rdata <= (!ce_n && !oe_n) ? mem_rd(s_addr) : '0;
   end

   // ---------------- transaction-level golden memory ----------------
   logic [DW-1:0] gold [int];

   function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
      if (gold.exists(int'(a))) return gold[int'(a)];
      return init_pat(a);
   endfunction

   task automatic gold_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
      logic [DW-1:0] w;
      w = gold_rd(a);
      if (b[0]) w[7:0]  = d[7:0];
      if (b[1]) w[15:8] = d[15:8];
      gold[int'(a)] = w;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},      ack, 0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rdata"},    rdata, 0);
      check({tag, "_addr"},     s_addr, 0);
      check({tag, "_wdata"},    s_wdata, 0);
      check({tag, "_dq_oe"},    dq_oe, 0);
      check({tag, "_strobes"},  pins, 5'b11111);
   endtask

   typedef struct packed {
      logic [1:0]    id;
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0]    be;
      logic [2:0]    ack;   // expected grant
      logic [4:0]    pins;  // {ce_n,oe_n,we_n,lb_n,ub_n} one cycle after grant
      logic          dq;    // dq_oe one cycle after grant
   } vec_t;

   vec_t vt [9];

   initial begin
      vec_t          v;
      logic          is_wr;
      logic [DW-1:0] exp_d;
      logic [2:0]    exp_a;
      logic [2:0]    pend, e, pv0, pv1;
      logic [DW-1:0] pd0, pd1, nd;
      logic          blk, pref_lb, oth, frc, gwr;
      int            gi, cnt;

      vt[0] = '{2'd2, 1'b1, 18'h00010, 16'hA5C3, 2'b11, 3'b100, 5'b01000, 1'b1};
      vt[1] = '{2'd1, 1'b0, 18'h00010, 16'h0000, 2'b11, 3'b010, 5'b00100, 1'b0};
      vt[2] = '{2'd1, 1'b1, 18'h3FFFF, 16'h1234, 2'b11, 3'b010, 5'b01000, 1'b1};
      vt[3] = '{2'd2, 1'b0, 18'h3FFFF, 16'h0000, 2'b01, 3'b100, 5'b00101, 1'b0};
      vt[4] = '{2'd0, 1'b1, 18'h00020, 16'hBEEF, 2'b11, 3'b001, 5'b00100, 1'b0};
      vt[5] = '{2'd2, 1'b1, 18'h00010, 16'hFFFF, 2'b10, 3'b100, 5'b01010, 1'b1};
      vt[6] = '{2'd0, 1'b0, 18'h00010, 16'h0000, 2'b11, 3'b001, 5'b00100, 1'b0};
      vt[7] = '{2'd1, 1'b1, 18'h00021, 16'h9999, 2'b00, 3'b010, 5'b01011, 1'b1};
      vt[8] = '{2'd2, 1'b0, 18'h00021, 16'h0000, 2'b11, 3'b100, 5'b00100, 1'b0};

      req = '0; wr = '0; addr = '0; wdata = '0; be = '0;

      // ---- reset state, with requests raised to show acks are gated ----
      #1 rst = 1'b1;
      req = 3'b111;
      tick();
      tick();
      @(negedge clk);
      check_reset_outputs("reset");
      req = '0;
      tick();
      rst = 1'b0;
      tick();

      // ---- directed single transactions from idle ----
      for (int k = 0; k < 9; k++) begin
         v = vt[k];
         req = '0;
         req[v.id] = 1'b1; wr[v.id] = v.wr; addr[v.id] = v.a;
         wdata[v.id] = v.d; be[v.id] = v.be;
         @(negedge clk);
         check("tbl_ack", ack, v.ack);
         is_wr = v.wr && (v.id != 2'd0);
         exp_d = gold_rd(v.a);
         if (is_wr) gold_wr(v.a, v.d, v.be);
         tick();
         req = '0;
         @(negedge clk);
         check("tbl_pins_t1", pins, v.pins);
         check("tbl_addr_t1", s_addr, v.a);
         check("tbl_dqoe_t1", dq_oe, v.dq);
         if (is_wr) check("tbl_wdata_t1", s_wdata, v.d);
         tick();
         @(negedge clk);
         if (is_wr) begin
            check("tbl_wen_t2",   we_n, 1);
            check("tbl_addr_t2",  s_addr, v.a);
            check("tbl_wdata_t2", s_wdata, v.d);
            check("tbl_dqoe_t2",  dq_oe, 1);
            check("tbl_norv_t2",  rd_valid, 0);
         end else begin
            check("tbl_rv_t2",    rd_valid, v.ack);
            check("tbl_rdata_t2", rdata, exp_d);
         end
         tick();
         tick();
      end

      // ---- VGA burst 0x100..0x107, back-to-back reads ----
      wr[0] = 1'b0; be[0] = 2'b11;
      for (int c = 0; c < 10; c++) begin
         req[0] = (c < 8);
         addr[0] = AW'(18'h100 + c);
         @(negedge clk);
         check("burst_ack", ack, (c < 8) ? 3'b001 : 3'b000);
         if (c >= 2) begin
            check("burst_rv", rd_valid, 3'b001);
            check("burst_rdata", rdata, gold_rd(AW'(18'h100 + c - 2)));
         end else begin
            check("burst_rv_lead", rd_valid, 0);
         end
         tick();
      end
      req = '0;
      @(negedge clk);
      check("burst_rv_tail", rd_valid, 0);
      tick();

      // ---- GPU and LB contending: alternate, GPU first ----
      do_reset();
      wr = '0;
      req = 3'b110;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_ack", ack, (k % 2 == 0) ? 3'b010 : 3'b100);
         tick();
      end
      req = '0;
      tick(); tick(); tick();

      // ---- all three contending ----
      do_reset();
      req = 3'b111;
      for (int k = 0; k < 18; k++) begin
`ifdef SYN_VCORTEX_SRAM_ARB_STARVE_CNT_EN
         exp_a = (k == LIM) ? 3'b010 : (k == 2 * LIM + 1) ? 3'b100 : 3'b001;
`else
         exp_a = 3'b001;
`endif
         @(negedge clk);
         check("starve_ack", ack, exp_a);
         tick();
      end
      req = '0;
      tick(); tick(); tick();

      // ---- reset asserted while a read is in RD ----
      do_reset();
      req[0] = 1'b1; addr[0] = 18'h00123; be[0] = 2'b11;
      @(negedge clk);
      check("rstrd_ack", ack, 3'b001);
      tick();
      req = '0;
      check("rstrd_in_rd", oe_n, 0);
      rst = 1'b1;
      #1;
      check_reset_outputs("rstrd");
      tick();
      @(negedge clk);
      check("rstrd_no_rv", rd_valid, 0);
      rst = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rstrd_no_rv_late", rd_valid, 0);
      tick();

      // ---- random traffic vs transaction-level model ----
      do_reset();
      pend = '0; blk = 1'b0; pref_lb = 1'b0; cnt = 0;
      pv0 = '0; pv1 = '0; pd0 = '0; pd1 = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  pend[i]  = 1'b1;
                  wr[i]    = 1'($urandom_range(0, 1));
                  addr[i]  = AW'($urandom_range(0, 15));
                  wdata[i] = DW'($urandom);
                  be[i]    = 2'($urandom_range(0, 3));
               end
            end else if ($urandom_range(0, 31) == 0) begin
               pend[i] = 1'b0;  // abandon before grant: must leave no trace
            end
         end
         req = pend;
         @(negedge clk);

         oth = req[1] | req[2];
`ifdef SYN_VCORTEX_SRAM_ARB_STARVE_CNT_EN
         frc = (cnt >= LIM) && oth;
`else
         frc = 1'b0;
`endif
         e = '0;
         if (!blk) begin
            if (req[0] && !frc)   e = 3'b001;
            else if (req[1] && req[2]) e = pref_lb ? 3'b100 : 3'b010;
            else if (req[1])      e = 3'b010;
            else if (req[2])      e = 3'b100;
         end
         check("rand_ack", ack, e);
         check("rand_rv", rd_valid, pv0);
         if (pv0 != 0) check("rand_rdata", rdata, pd0);
         check("rand_no_contention", dq_oe & ~oe_n, 0);

         gi  = e[2] ? 2 : e[1] ? 1 : 0;
         gwr = (e != 0) && (gi != 0) && wr[gi];
         nd  = '0;
         if (gwr)          gold_wr(addr[gi], wdata[gi], be[gi]);
         else if (e != 0)  nd = gold_rd(addr[gi]);
         pv0 = pv1; pd0 = pd1;
         pv1 = gwr ? 3'b000 : e;
         pd1 = nd;
         blk = gwr;
         if (e[1])      pref_lb = 1'b1;
         else if (e[2]) pref_lb = 1'b0;
         if (!oth)                cnt = 0;
         else if (e[0])           cnt = (cnt < LIM) ? cnt + 1 : cnt;
         else if (e[1] || e[2])   cnt = 0;
         pend = pend & ~e;
         tick();
      end
      req = '0;
      tick(); tick(); tick(); tick();

      // SRAM contents must match the set of acknowledged writes.
      for (int a = 0; a < 16; a++)
         check("rand_mem", mem_rd(AW'(a)), gold_rd(AW'(a)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_syn_vcortex_sram_arb
`default_nettype wire
